// File: rtl/vedio_frame_sched.sv
// Frame-level sequencer: steps src_sel through the sources, counting completed
// destination frames per source, switching only in a shared vertical blank.
module vedio_frame_sched #(
  parameter int SRC_NUM        = 4,
  parameter int SEL_DW         = 2,
  parameter int FRAMES_PER_SRC = 2,
  parameter int FCNT_DW        = 8,
  parameter int TIMEOUT_CLK    = 2_000_000,
  parameter int TOUT_DW        = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               src_vsync,
  input  logic               dst_vsync,
  output logic [SEL_DW-1:0]  src_sel,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [FCNT_DW-1:0] frame_cnt,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_SOF = 3'd1,
    S_RUN      = 3'd2,
    S_SWITCH   = 3'd3,
    S_DONE     = 3'd4,
    S_ERR      = 3'd5
  } state_t;

  localparam logic [SEL_DW-1:0]  SEL_LAST  = SEL_DW'(SRC_NUM - 1);
  localparam logic [FCNT_DW-1:0] FCNT_MAX  = FCNT_DW'(FRAMES_PER_SRC);
  localparam logic [TOUT_DW-1:0] TOUT_LAST = TOUT_DW'(TIMEOUT_CLK - 1);

  state_t             state, state_nx;
  logic [SEL_DW-1:0]  sel_nx;
  logic [FCNT_DW-1:0] cnt_nx;
  logic [TOUT_DW-1:0] wd, wd_nx;
  logic               src_q, dst_q, dst_qq;
  logic               dst_rise, dst_fall;

  assign dst_rise  = dst_q & ~dst_qq;
  assign dst_fall  = ~dst_q & dst_qq;
  assign state_dbg = state;

  always_comb begin
    state_nx = state;
    sel_nx   = src_sel;
    cnt_nx   = frame_cnt;
    wd_nx    = wd;
    if (abort) begin
      state_nx = S_IDLE;
      wd_nx    = '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_nx = S_WAIT_SOF;
            sel_nx   = '0;
            cnt_nx   = '0;
            wd_nx    = '0;
          end
        end
        S_WAIT_SOF, S_RUN, S_SWITCH: begin
          wd_nx = wd + TOUT_DW'(1);
          // A stalled pipeline wins over any vsync event landing in the same cycle.
          if (wd == TOUT_LAST) begin
            state_nx = S_ERR;
            wd_nx    = '0;
          end else if (state == S_WAIT_SOF) begin
            if (dst_rise) begin
              state_nx = S_RUN;
              wd_nx    = '0;
            end
          end else if (state == S_RUN) begin
            if (dst_fall) begin
              cnt_nx = frame_cnt + FCNT_DW'(1);
              wd_nx  = '0;
              if (cnt_nx == FCNT_MAX)
                state_nx = (src_sel == SEL_LAST) ? S_DONE : S_SWITCH;
            end
          end else begin
            // Only move the shared select while both streams sit in blank.
            if (!src_q && !dst_q) begin
              state_nx = S_WAIT_SOF;
              sel_nx   = src_sel + SEL_DW'(1);
              cnt_nx   = '0;
              wd_nx    = '0;
            end
          end
        end
        default: begin
          state_nx = S_IDLE;
          wd_nx    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      src_sel   <= '0;
      frame_cnt <= '0;
      wd        <= '0;
      src_q     <= 1'b0;
      dst_q     <= 1'b0;
      dst_qq    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      src_sel   <= sel_nx;
      frame_cnt <= cnt_nx;
      wd        <= wd_nx;
      src_q     <= src_vsync;
      dst_q     <= dst_vsync;
      dst_qq    <= dst_q;
      busy      <= (state_nx == S_WAIT_SOF) || (state_nx == S_RUN) || (state_nx == S_SWITCH);
      done      <= (state_nx == S_DONE);
      err       <= (state_nx == S_ERR);
    end
  end

endmodule

// File: tb/tb_vedio_frame_sched.sv
// Directed bench for vedio_frame_sched: a frame generator drives both vsyncs
// from a cycle index, and expected values are hand-derived from that index.
module tb_vedio_frame_sched;

  localparam int SEL_DW  = 2;
  localparam int FCNT_DW = 8;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_RUN    = 3'd2;
  localparam logic [2:0] ST_SWITCH = 3'd3;
  localparam logic [2:0] ST_ERR    = 3'd5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic src_vsync = 1'b0;
  logic dst_vsync = 1'b0;
  logic [SEL_DW-1:0]  src_sel;
  logic               busy, done, err;
  logic [FCNT_DW-1:0] frame_cnt;
  logic [2:0]         state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // frame generator controls; gen_t is the cycle index of the values on the inputs
  int gen_t = 0;
  int gen_p = 200;
  int gen_a = 150;
  int gen_lag = 30;
  bit gen_run = 1'b0;
  bit gen_started = 1'b0;
  bit dst_hold = 1'b0;

  bit mon_en = 1'b0;
  bit fall_en = 1'b0;
  int viol = 0;
  int dst_falls = 0;
  logic [SEL_DW-1:0] prev_sel = '0;
  logic [SEL_DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  vedio_frame_sched #(
    .SRC_NUM(4), .SEL_DW(SEL_DW), .FRAMES_PER_SRC(2), .FCNT_DW(FCNT_DW),
    .TIMEOUT_CLK(500), .TOUT_DW(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .src_vsync(src_vsync), .dst_vsync(dst_vsync), .src_sel(src_sel),
    .busy(busy), .done(done), .err(err), .frame_cnt(frame_cnt),
    .state_dbg(state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (time %0t, gen_t %0d)", tag, got, exp, $time, gen_t);
    end
  endtask

  task automatic wait_t(input int k);
    int guard;
    guard = 0;
    while (gen_t < k && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (gen_t != k) check("wait_t", gen_t, k);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (gen_run) begin
        if (gen_started) gen_t++;
        gen_started = 1'b1;
        src_vsync = (gen_t % gen_p) < gen_a;
        dst_vsync = !dst_hold && (gen_t >= gen_lag) && (((gen_t - gen_lag) % gen_p) < gen_a);
      end else begin
        gen_started = 1'b0;
        gen_t = 0;
        src_vsync = 1'b0;
        dst_vsync = 1'b0;
      end
    end
  end

  // select-change monitor: order of indices and no change while either raw vsync is high
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && src_sel !== prev_sel) begin
        if (src_vsync || dst_vsync) viol++;
        if (exp_q.size() == 0) check("sel_seq_extra", src_sel, prev_sel);
        else check("sel_seq", src_sel, exp_q.pop_front());
      end
      prev_sel = src_sel;
    end
  end

  initial begin
    forever begin
      @(negedge dst_vsync);
      if (fall_en) dst_falls++;
    end
  end

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_sel", src_sel, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cnt", frame_cnt, 0);
    check("rst_state", state_dbg, ST_IDLE);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // nominal run with start held high the whole time
    mon_en = 1'b1;
    exp_q = {2'd1, 2'd2, 2'd3, 2'd0};
    start = 1'b1;
    @(negedge clk);
    check("t1_busy_lat", busy, 1);
    check("t1_state", state_dbg, ST_WAIT);
    gen_p = 200; gen_a = 150; gen_lag = 30;
    fall_en = 1'b1;
    gen_run = 1'b1;
    for (int i = 0; i < 4000 && !done; i++) @(negedge clk);
    check("t1_done", done, 1);
    check("t1_done_time", gen_t, 1582);
    check("t1_done_sel", src_sel, 3);
    check("t1_done_cnt", frame_cnt, 2);
    check("t1_done_busy", busy, 0);
    check("t1_dst_falls", dst_falls, 8);
    @(negedge clk);
    check("t1_rs_done", done, 0);
    check("t1_rs_busy", busy, 1);
    check("t1_rs_sel", src_sel, 0);
    check("t1_rs_cnt", frame_cnt, 0);
    start = 1'b0;
    mon_en = 1'b0;
    fall_en = 1'b0;
    pulse_abort();
    check("t1_abort_state", state_dbg, ST_IDLE);
    check("t1_seq_left", exp_q.size(), 0);
    gen_run = 1'b0;

    // late dst fall: SWITCH must sit out the source frame already under way
    gen_p = 200; gen_a = 100; gen_lag = 105;
    mon_en = 1'b1;
    exp_q = {2'd1};
    pulse_start();
    check("t2_busy", busy, 1);
    gen_run = 1'b1;
    wait_t(206);
    check("t2_cnt_pre", frame_cnt, 0);
    check("t2_state_run", state_dbg, ST_RUN);
    wait_t(207);
    check("t2_cnt_lat", frame_cnt, 1);
    wait_t(450);
    check("t2_sw_state", state_dbg, ST_SWITCH);
    check("t2_sw_sel", src_sel, 0);
    check("t2_sw_cnt", frame_cnt, 2);
    wait_t(501);
    check("t2_hold_sel", src_sel, 0);
    wait_t(502);
    check("t2_new_sel", src_sel, 1);
    check("t2_new_cnt", frame_cnt, 0);
    check("t2_new_state", state_dbg, ST_WAIT);
    wait_t(607);
    check("t2_sel1_cnt", frame_cnt, 1);
    wait_t(850);
    check("t2_sw1_state", state_dbg, ST_SWITCH);
    check("t2_sw1_sel", src_sel, 1);
    pulse_abort();
    check("t2_ab_state", state_dbg, ST_IDLE);
    check("t2_ab_sel", src_sel, 1);
    check("t2_ab_busy", busy, 0);
    check("t2_ab_done", done, 0);
    check("t2_ab_err", err, 0);
    mon_en = 1'b0;
    pulse_start();
    check("t2_re_busy", busy, 1);
    check("t2_re_sel", src_sel, 0);
    check("t2_seq_left", exp_q.size(), 0);
    check("sel_stable", viol, 0);
    gen_run = 1'b0;
    pulse_abort();

    // watchdog: dst stops after the first counted frame of index 1
    gen_p = 200; gen_a = 150; gen_lag = 30;
    pulse_start();
    gen_run = 1'b1;
    wait_t(600);
    check("t3_cnt", frame_cnt, 1);
    check("t3_sel", src_sel, 1);
    dst_hold = 1'b1;
    wait_t(1081);
    check("t3_err_pre", err, 0);
    check("t3_busy_pre", busy, 1);
    wait_t(1082);
    check("t3_err", err, 1);
    check("t3_busy", busy, 0);
    check("t3_err_sel", src_sel, 1);
    check("t3_err_state", state_dbg, ST_ERR);
    pulse_start();
    check("t3_re_busy", busy, 1);
    check("t3_re_err", err, 0);
    check("t3_re_sel", src_sel, 0);
    gen_run = 1'b0;
    dst_hold = 1'b0;
    pulse_abort();
    check("t3_ab_busy", busy, 0);

    // asynchronous reset in RUN at index 2
    pulse_start();
    gen_run = 1'b1;
    wait_t(1000);
    check("t4_sel", src_sel, 2);
    check("t4_cnt", frame_cnt, 1);
    check("t4_state", state_dbg, ST_RUN);
    rst_n = 1'b0;
    #1;
    check("t4_async_sel", src_sel, 0);
    check("t4_async_cnt", frame_cnt, 0);
    check("t4_async_busy", busy, 0);
    check("t4_async_state", state_dbg, ST_IDLE);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    gen_run = 1'b0;
    repeat (10) @(negedge clk);
    check("t4_idle_state", state_dbg, ST_IDLE);
    check("t4_idle_busy", busy, 0);
    pulse_start();
    check("t4_re_busy", busy, 1);
    pulse_abort();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
